// File: rtl/bm_fifo.sv
// bm_fifo: branch-metric buffer between the BM unit and the ACS array.
// Stores up to DEPTH entries of {data_id, NCH packed metrics} with
// valid/ready handshakes on both sides; metrics pass through bit-exact.
//
// Ports:
//   BM_clk, BM_rst         clock (rising), async active-high reset
//   BM_in, data_id         incoming entry (channel k at [k*BM_W +: BM_W])
//   in_valid, in_ready     producer handshake
//   BM_out, data_id_out    head entry, forced to 0 when empty
//   out_valid, out_ready   consumer handshake
//   level, full, empty     occupancy
//   id_err                 sticky tag-sequence error
//
// Optional feature macro: BM_ID_CHECK_EN
//   defined   -> tag-sequence tracking drives id_err
//   undefined -> id_err tied to 0, no tracking logic

module bm_fifo #(
    parameter int NCH   = 4,
    parameter int BM_W  = 7,
    parameter int ID_W  = 4,
    parameter int DEPTH = 8
) (
    input  logic                       BM_clk,
    input  logic                       BM_rst,
    input  logic [NCH*BM_W-1:0]        BM_in,
    input  logic [ID_W-1:0]            data_id,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [NCH*BM_W-1:0]        BM_out,
    output logic [ID_W-1:0]            data_id_out,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       full,
    output logic                       empty,
    output logic                       id_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int DW = NCH * BM_W;
    localparam int EW = ID_W + DW;

    logic [EW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] cnt;
    logic [EW-1:0] head;
    logic          wr_en;
    logic          rd_en;

    // Occupancy comes from the counter, not a pointer compare, so the
    // naturally wrapping pointers never need an extra lap bit.
    assign full      = (cnt == LW'(DEPTH));
    assign empty     = (cnt == '0);
    assign level     = cnt;
    // Held low during reset so nothing is offered as accepted then.
    assign in_ready  = !full && !BM_rst;
    assign out_valid = !empty;

    assign wr_en = in_valid && in_ready;
    assign rd_en = out_valid && out_ready;

    // Storage has no reset; stale words stay hidden behind empty.
    always_ff @(posedge BM_clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= {data_id, BM_in};
        end
    end

    always_ff @(posedge BM_clk or posedge BM_rst) begin
        if (BM_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({wr_en, rd_en})
                2'b10:   cnt <= cnt + LW'(1);
                2'b01:   cnt <= cnt - LW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Head is a pure function of the registered read pointer, so it
    // holds steady while the consumer stalls.
    assign head        = mem[rd_ptr];
    assign BM_out      = empty ? '0 : head[DW-1:0];
    assign data_id_out = empty ? '0 : head[EW-1:DW];

`ifdef BM_ID_CHECK_EN
    logic            have_base;
    logic [ID_W-1:0] exp_id;
    logic            id_err_q;

    // First write after reset only seeds the baseline; every later
    // write is compared, then the baseline follows the received tag.
    always_ff @(posedge BM_clk or posedge BM_rst) begin
        if (BM_rst) begin
            have_base <= 1'b0;
            exp_id    <= '0;
            id_err_q  <= 1'b0;
        end else if (wr_en) begin
            have_base <= 1'b1;
            exp_id    <= data_id + ID_W'(1);
            if (have_base && (data_id != exp_id)) begin
                id_err_q <= 1'b1;
            end
        end
    end

    assign id_err = id_err_q;
`else
    assign id_err = 1'b0;
`endif

endmodule
